// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 shift-add multiplier / restoring divider, one step per cycle.
// Build option MULDIV_DIV_EN enables the UDIV datapath; without it op 11 completes as illegal.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags,
   output logic             div0,
   output logic             illegal
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_UMULL = 2'b01;
   localparam logic [1:0] OP_SMULL = 2'b10;
   localparam logic [1:0] OP_UDIV  = 2'b11;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_FIN = 2'd3} state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [1:0]         r_op;
   logic               r_neg;
   logic [WIDTH-1:0]   r_a;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_busy;
   logic               r_done;
   logic               r_div0;
   logic               r_illegal;
   logic [WIDTH-1:0]   r_lo;
   logic [WIDTH-1:0]   r_hi;
   logic [3:0]         r_flags;

   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_acc;
   logic [2*WIDTH-1:0] w_prod;
   logic               w_long;
   logic [WIDTH-1:0]   w_mul_hi;
   logic [3:0]         w_mul_flags;

   // Operand magnitudes, one shift-add step, and the signed fix-up of the final product
   always_comb begin
      w_a_mag     = (op == OP_SMULL && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      w_b_mag     = (op == OP_SMULL && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
      w_mul_acc   = {w_mul_sum, r_acc[WIDTH-1:1]};
      w_prod      = r_neg ? (~w_mul_acc + (2*WIDTH)'(1)) : w_mul_acc;
      w_long      = (r_op == OP_UMULL) || (r_op == OP_SMULL);
      w_mul_hi    = w_long ? w_prod[2*WIDTH-1:WIDTH] : {WIDTH{1'b0}};
      w_mul_flags = {(w_long ? w_prod[2*WIDTH-1] : w_prod[WIDTH-1]),
                     (w_long ? (w_prod == {(2*WIDTH){1'b0}}) : (w_prod[WIDTH-1:0] == {WIDTH{1'b0}})),
                     2'b00};
   end

`ifdef MULDIV_DIV_EN
   logic [WIDTH-1:0]   r_b;
   logic [WIDTH:0]     w_trial;
   logic [WIDTH:0]     w_diff;
   logic               w_qbit;
   logic [2*WIDTH-1:0] w_div_acc;

   // Restoring step: acc = {partial remainder, dividend bits shifting into quotient}
   always_comb begin
      w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_diff    = w_trial - {1'b0, r_b};
      w_qbit    = ~w_diff[WIDTH];
      w_div_acc = {(w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]), r_acc[WIDTH-2:0], w_qbit};
   end
`endif

   // Control FSM, iteration datapath and held result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= {CW{1'b0}};
         r_op      <= 2'b00;
         r_neg     <= 1'b0;
         r_a       <= {WIDTH{1'b0}};
         r_acc     <= {(2*WIDTH){1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_div0    <= 1'b0;
         r_illegal <= 1'b0;
         r_lo      <= {WIDTH{1'b0}};
         r_hi      <= {WIDTH{1'b0}};
         r_flags   <= 4'b0000;
`ifdef MULDIV_DIV_EN
         r_b       <= {WIDTH{1'b0}};
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE, S_FIN: begin
               if (start) begin
                  r_op   <= op;
                  r_a    <= w_a_mag;
                  r_neg  <= (op == OP_SMULL) && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_acc  <= (op == OP_UDIV) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, w_b_mag};
                  r_cnt  <= CW'(WIDTH-1);
                  r_busy <= 1'b1;
                  r_state <= (op == OP_UDIV) ? S_DIV : S_MUL;
`ifdef MULDIV_DIV_EN
                  r_b    <= b;
`endif
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_MUL: begin
               r_acc <= w_mul_acc;
               if (r_cnt == {CW{1'b0}}) begin
                  r_lo      <= w_prod[WIDTH-1:0];
                  r_hi      <= w_mul_hi;
                  r_flags   <= w_mul_flags;
                  r_div0    <= 1'b0;
                  r_illegal <= 1'b0;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_FIN;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            S_DIV: begin
`ifdef MULDIV_DIV_EN
               if (r_b == {WIDTH{1'b0}}) begin
                  r_lo      <= {WIDTH{1'b1}};
                  r_hi      <= r_acc[WIDTH-1:0];
                  r_flags   <= 4'b1000;
                  r_div0    <= 1'b1;
                  r_illegal <= 1'b0;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_FIN;
               end else begin
                  r_acc <= w_div_acc;
                  if (r_cnt == {CW{1'b0}}) begin
                     r_lo      <= w_div_acc[WIDTH-1:0];
                     r_hi      <= w_div_acc[2*WIDTH-1:WIDTH];
                     r_flags   <= {w_div_acc[WIDTH-1], (w_div_acc[WIDTH-1:0] == {WIDTH{1'b0}}), 2'b00};
                     r_div0    <= 1'b0;
                     r_illegal <= 1'b0;
                     r_done    <= 1'b1;
                     r_busy    <= 1'b0;
                     r_state   <= S_FIN;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
`else
               r_lo      <= {WIDTH{1'b0}};
               r_hi      <= {WIDTH{1'b0}};
               r_flags   <= 4'b0100;
               r_div0    <= 1'b0;
               r_illegal <= 1'b1;
               r_done    <= 1'b1;
               r_busy    <= 1'b0;
               r_state   <= S_FIN;
`endif
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign result_lo = r_lo;
   assign result_hi = r_hi;
   assign flags     = r_flags;
   assign div0      = r_div0;
   assign illegal   = r_illegal;

endmodule
